// File: rtl/pads_oen_sequencer_pkg.sv
// Shared pad-ring constants and sequencer state encoding.
// Pad indices follow the caravel pad map; reset defaults park every pad as a pulled input.
package pads_oen_sequencer_pkg;
  localparam int NPADS = 44;

  localparam int PAD_JTAG      = 0;
  localparam int PAD_SDO       = 1;
  localparam int PAD_TXCLK     = 35;
  localparam int PAD_IOCLK     = 36;
  localparam int PAD_CLOCK     = 38;
  localparam int PAD_FLASH_CSB = 39;
  localparam int PAD_FLASH_CLK = 40;
  localparam int PAD_FLASH_IO0 = 41;
  localparam int PAD_FLASH_IO1 = 42;
  localparam int PAD_GPIO      = 43;

  localparam logic [NPADS-1:0] PAD_OEN_RST = '1;
  localparam logic [NPADS-1:0] PAD_REN_RST = '0;

  typedef enum logic [2:0] {
    IDLE, RELEASE, WAIT_R, DRIVE, WAIT_D, DONE
  } seq_state_t;
endpackage

// File: rtl/pads_oen_sequencer_timer.sv
// Settle counter: loads a wait length, counts down, flags the last wait cycle.
module pads_settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             expire
);
  always_ff @(posedge clk) begin
    if (rst)                      count <= '0;
    else if (load)                count <= value;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign expire = (count == CNT_W'(1));
endmodule

// File: rtl/pads_oen_sequencer.sv
// Applies pad direction/pull changes break-before-make: release drivers and enable
// pulls first, settle, then enable new drivers and apply remaining pull changes.
module pads_oen_sequencer #(
  parameter int NPADS         = pads_oen_sequencer_pkg::NPADS,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NPADS-1:0] cfg_oe_n,
  input  logic [NPADS-1:0] cfg_re_n,
  output logic [NPADS-1:0] pad_oe_n,
  output logic [NPADS-1:0] pad_re_n,
  output logic             busy,
  output logic             done,
  output logic [15:0]      seq_count
);
  import pads_oen_sequencer_pkg::*;

  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

  seq_state_t       state;
  logic [NPADS-1:0] tgt_oe_n, tgt_re_n;
  logic [NPADS-1:0] rel_oe, rel_re;
  logic             cfg_rel_any;
  logic             tmr_load, tmr_dec, tmr_expire;
  logic [CNT_W-1:0] tmr_count;

  // Release set of the latched target, used in RELEASE
  assign rel_oe = tgt_oe_n & ~pad_oe_n;
  assign rel_re = ~tgt_re_n & pad_re_n;
  // Same set from the live inputs, used in IDLE to pick the first phase
  assign cfg_rel_any = |(cfg_oe_n & ~pad_oe_n) | |(~cfg_re_n & pad_re_n);

  assign tmr_load = (state == RELEASE) || (state == DRIVE);
  assign tmr_dec  = (state == WAIT_R)  || (state == WAIT_D);

  pads_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .value  (SETTLE),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      pad_oe_n  <= '1;
      pad_re_n  <= '0;
      tgt_oe_n  <= '1;
      tgt_re_n  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seq_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if ({cfg_oe_n, cfg_re_n} != {pad_oe_n, pad_re_n}) begin
            tgt_oe_n <= cfg_oe_n;
            tgt_re_n <= cfg_re_n;
            busy     <= 1'b1;
            state    <= cfg_rel_any ? RELEASE : DRIVE;
          end
        end
        RELEASE: begin
          pad_oe_n <= pad_oe_n | rel_oe;
          pad_re_n <= pad_re_n & ~rel_re;
          state    <= (SETTLE_CYCLES == 0) ? DRIVE : WAIT_R;
        end
        WAIT_R: if (tmr_expire) state <= DRIVE;
        DRIVE: begin
          pad_oe_n <= tgt_oe_n;
          pad_re_n <= tgt_re_n;
          state    <= (SETTLE_CYCLES == 0) ? DONE : WAIT_D;
        end
        WAIT_D: if (tmr_expire) state <= DONE;
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          seq_count <= seq_count + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^tmr_count;
endmodule

// File: tb/tb_pads_oen_sequencer.sv
// Drives two sequencers (settle 0 and 4) with shared stimulus and checks them
// against edge-by-edge expectations derived from the phase/latency rules.
module tb_pads_oen_sequencer;
  localparam int N   = 44;
  localparam int S_B = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] cfg_oe_n, cfg_re_n;
  logic [N-1:0] poe [2];
  logic [N-1:0] pre [2];
  logic         busy [2];
  logic         done [2];
  logic [15:0]  cnt  [2];

  int checks = 0;
  int errors = 0;

  logic [N-1:0] m_oe = '1;
  logic [N-1:0] m_re = '0;
  logic [15:0]  m_cnt = '0;

  always #5 clk = ~clk;

  pads_oen_sequencer #(.NPADS(N), .SETTLE_CYCLES(0), .CNT_W(8)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_oe_n(cfg_oe_n), .cfg_re_n(cfg_re_n),
    .pad_oe_n(poe[0]), .pad_re_n(pre[0]), .busy(busy[0]), .done(done[0]), .seq_count(cnt[0]));

  pads_oen_sequencer #(.NPADS(N), .SETTLE_CYCLES(S_B), .CNT_W(8)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_oe_n(cfg_oe_n), .cfg_re_n(cfg_re_n),
    .pad_oe_n(poe[1]), .pad_re_n(pre[1]), .busy(busy[1]), .done(done[1]), .seq_count(cnt[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input int d, input string tag);
    chk({tag, "_oe"}, 64'(poe[d]), 64'(m_oe));
    chk({tag, "_re"}, 64'(pre[d]), 64'(m_re));
    chk({tag, "_busy"}, 64'(busy[d]), 64'(0));
    chk({tag, "_done"}, 64'(done[d]), 64'(0));
    chk({tag, "_cnt"}, 64'(cnt[d]), 64'(m_cnt));
  endtask

  // Called just after a negedge; the next posedge is edge 0 of the sequence.
  task automatic run_seq(input logic [N-1:0] noe, input logic [N-1:0] nre, input bit flip);
    logic [N-1:0] roe, rre, eoe, ere, prev_oe, cur_oe;
    bit has_rel, act;
    int dn [2];
    int tg [2];
    int s;
    act     = ({noe, nre} != {m_oe, m_re});
    roe     = noe & ~m_oe;
    rre     = ~nre & m_re;
    has_rel = |{roe, rre};
    for (int d = 0; d < 2; d++) begin
      s     = (d == 0) ? 0 : S_B;
      dn[d] = has_rel ? 2 * s + 3 : s + 2;
      tg[d] = has_rel ? s + 2 : 1;
    end
    cfg_oe_n = noe;
    cfg_re_n = nre;
    prev_oe  = poe[1];
    for (int e = 0; e <= dn[1] + 1; e++) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!flip || e <= dn[d]) begin
          if (!act) begin
            chk_model(d, "noseq");
          end else begin
            eoe = (e >= tg[d]) ? noe : (has_rel && e >= 1) ? (m_oe | roe) : m_oe;
            ere = (e >= tg[d]) ? nre : (has_rel && e >= 1) ? (m_re & ~rre) : m_re;
            chk("seq_oe", 64'(poe[d]), 64'(eoe));
            chk("seq_re", 64'(pre[d]), 64'(ere));
            chk("seq_busy", 64'(busy[d]), 64'(e < dn[d]));
            chk("seq_done", 64'(done[d]), 64'(e == dn[d]));
            chk("seq_cnt", 64'(cnt[d]), 64'((e >= dn[d]) ? m_cnt + 16'd1 : m_cnt));
          end
        end
      end
      cur_oe = poe[1];
      chk("oe_no_overlap", 64'(((prev_oe & ~cur_oe) != '0) && ((~prev_oe & cur_oe) != '0)), 64'(0));
      prev_oe = cur_oe;
      if (flip && e == 3) cfg_oe_n[22] = ~cfg_oe_n[22];
    end
    if (act) begin
      m_oe  = noe;
      m_re  = nre;
      m_cnt = m_cnt + 16'd1;
    end
    if (flip) begin
      repeat (30) @(negedge clk);
      m_oe[22] = ~m_oe[22];
      m_cnt    = m_cnt + 16'd1;
      for (int d = 0; d < 2; d++) chk_model(d, "flip_final");
    end
  endtask

  initial begin
    logic [N-1:0] boot, noe, nre;
    logic [63:0]  r1, r2;

    boot = '1;
    boot[1] = 1'b0;
    boot[6] = 1'b0;
    for (int i = 22; i <= 35; i++) boot[i] = 1'b0;
    for (int i = 39; i <= 41; i++) boot[i] = 1'b0;
    cfg_oe_n = boot;
    cfg_re_n = '1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk_model(d, "reset");
    rst = 1'b0;

    // Boot map: pure drive-enable plus pull-disable, so no release phase
    run_seq(boot, '1, 1'b0);

    // Pad 1 output->input, pad 2 input->output
    noe = m_oe;
    noe[1] = 1'b1;
    noe[2] = 1'b0;
    run_seq(noe, m_re, 1'b0);

    // Reset during WAIT_D of the settle-4 instance
    noe = ~m_oe;
    nre = ~m_re;
    cfg_oe_n = noe;
    cfg_re_n = nre;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("busy_before_abort", 64'(busy[1]), 64'(1));
    rst = 1'b1;
    cfg_oe_n = '1;
    cfg_re_n = '0;
    @(posedge clk); @(negedge clk);
    m_oe = '1; m_re = '0; m_cnt = '0;
    for (int d = 0; d < 2; d++) chk_model(d, "abort");
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk_model(d, "post_abort");
    end

    // Random targets
    for (int k = 0; k < 8; k++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      run_seq(r1[N-1:0], r2[N-1:0], 1'b0);
    end

    // Input change while busy is deferred to a follow-up sequence
    noe = m_oe;
    noe[5] = ~noe[5];
    noe[40] = ~noe[40];
    run_seq(noe, ~m_re, 1'b1);

    // Glitch restored before being sampled starts nothing
    cfg_oe_n[0] = ~cfg_oe_n[0];
    #1 cfg_oe_n[0] = ~cfg_oe_n[0];
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk_model(d, "glitch");
    end

    // Idle stretch with matching config
    repeat (100) begin
      @(negedge clk);
      chk_model(1, "idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
